board_port_arbiter: RTL
=======================

Name: board_port_arbiter

Overview:
- Control-clock-domain sequencer that owns port 1 (read/write port) of one board_mem instance.
- Shares that port between two requesters with a req/gnt/done handshake:
  - requester A: game FSM
  - requester B: link/shot handler
- Also runs a hardware board-clear sweep that writes CLR_VALUE to every valid cell.
- One instance sits between the requesters and each board_mem port 1; the VGA-side port 2 is untouched.

Parameters:
- DATA_WIDTH, 2, cell width in bits.
- X_ADDR_WIDTH, 4, x field width; address = {y, x}.
- Y_ADDR_WIDTH, 4, y field width.
- X_SIZE, 12, valid columns 0..X_SIZE-1.
- Y_SIZE, 12, valid rows 0..Y_SIZE-1.
- RD_LATENCY, 1, cycles from address applied to read_data1 valid (1..3).
- CLR_VALUE, 2'b00, value written by the clear sweep.

Ports:
- clk  in  1  control clock
- rst  in  1  asynchronous, active-high reset
- clr_start  in  1  single-cycle pulse; request board clear
- clr_busy  out  1  high while the sweep runs
- clr_done  out  1  single-cycle pulse after the last cell is written
- a_req  in  1  requester A access request; held until a_done
- a_w_nr  in  1  A: 1 = write, 0 = read
- a_addr  in  X+Y  A cell address {y, x}
- a_wdata  in  DATA_WIDTH  A write data
- a_gnt  out  1  A granted; high from grant until a_done
- a_rdata  out  DATA_WIDTH  A read data; held until the next A read
- a_done  out  1  single-cycle completion pulse for A
- b_req, b_w_nr, b_addr, b_wdata, b_gnt, b_rdata, b_done  same as A, for requester B
- mem_addr  out  X+Y  to board_mem addr1
- mem_wdata  out  DATA_WIDTH  to board_mem write_data1
- mem_w_nr  out  1  to board_mem w_nr
- mem_rdata  in  DATA_WIDTH  from board_mem read_data1

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, mem_w_nr = 0, state IDLE, round-robin pointer = A.
- States: IDLE, CLEAR, ACCESS, RD_WAIT, DONE.
- Priority in IDLE: clr_start > requesters.
  - clr_start sampled high in IDLE -> CLEAR next cycle.
  - clr_start in any other state is ignored (not queued).
- CLEAR:
  - One cell per cycle, x inner loop 0..X_SIZE-1, y outer loop 0..Y_SIZE-1.
  - mem_w_nr = 1, mem_wdata = CLR_VALUE, clr_busy = 1.
  - Exactly X_SIZE*Y_SIZE = 144 write cycles; never touches x >= X_SIZE or y >= Y_SIZE.
  - After the last cell: clr_done pulse for 1 cycle, clr_busy drops in the same cycle, return to IDLE.
- Grant (IDLE, no clear pending):
  - Only one request -> grant it.
  - Both requests -> grant the requester the round-robin pointer names; pointer flips to the other requester after every completed access.
  - gnt rises the cycle after req is sampled.
  - On grant, address, write flag and write data are latched internally; requester inputs are don't-care afterwards.
- ACCESS, write: mem_w_nr = 1 for exactly one cycle with the latched address/data -> DONE.
- ACCESS, read: mem_w_nr = 0 and address driven -> RD_WAIT.
  - RD_WAIT holds the address for RD_LATENCY cycles, then captures mem_rdata into x_rdata -> DONE.
- DONE: x_done = 1 for one cycle, x_gnt drops in the same cycle, mem_w_nr = 0 -> IDLE.
- Requester must deassert req in the cycle after done. A req still high two cycles after done is a new request.
- Latency, req high to done:
  - write: 3 cycles
  - read: 3 + RD_LATENCY cycles
- Outside CLEAR/ACCESS: mem_w_nr = 0; mem_addr holds its last value.
- Address wrap: a_addr/b_addr with x >= X_SIZE or y >= Y_SIZE are forwarded unchanged (board_mem ignores them); done still pulses.
- Reset mid-clear or mid-access: sweep aborts, gnt/done/busy go to 0, no done pulse is issued.

Optional Feature:
- BOARD_ARB_FIXED_PRIO_EN defined: requester A always wins simultaneous requests; the round-robin pointer is removed.
- Not defined: round-robin as described above.
- Clear priority is identical in both builds.

Test Plan:
- Reset, then clr_start pulse -> 144 consecutive write cycles; addresses 0x00..0x0B, 0x10..0x1B, ..., 0xB0..0xBB; clr_done 1 cycle after address 0xBB; clr_busy high for exactly 144 cycles.
- A write addr 0x35 data 2'b10 -> one mem_w_nr pulse at 0x35; a_done 3 cycles after a_req; then A read 0x35 with RD_LATENCY=1 -> a_rdata = 2'b10, a_done 4 cycles after a_req.
- a_req and b_req rise together, both repeating 4 times -> grants alternate A, B, A, B, ... With BOARD_ARB_FIXED_PRIO_EN -> A served every time while A keeps requesting.
- clr_start pulsed during a B write -> B completes, clr_start ignored, no sweep; a clr_start pulsed in IDLE together with a_req -> sweep runs first, A granted after clr_done.
- rst asserted at sweep cell 50 -> clr_busy = 0 immediately, no clr_done, mem_w_nr = 0; a new clr_start after reset runs a full 144-cell sweep.

Source files
------------

// File: rtl/board_port_arbiter.sv
// Port-1 sequencer for board_mem: arbitrates requesters A/B and runs a full-board clear sweep.
// Optional macro BOARD_ARB_FIXED_PRIO_EN: requester A always wins simultaneous requests.
module board_port_arbiter #(
    parameter int DATA_WIDTH   = 2,
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int X_SIZE       = 12,
    parameter int Y_SIZE       = 12,
    parameter int RD_LATENCY   = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr_start,
    output logic                                 clr_busy,
    output logic                                 clr_done,
    input  logic                                 a_req,
    input  logic                                 a_w_nr,
    input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]                a_wdata,
    output logic                                 a_gnt,
    output logic [DATA_WIDTH-1:0]                a_rdata,
    output logic                                 a_done,
    input  logic                                 b_req,
    input  logic                                 b_w_nr,
    input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]                b_wdata,
    output logic                                 b_gnt,
    output logic [DATA_WIDTH-1:0]                b_rdata,
    output logic                                 b_done,
    output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic                                 mem_w_nr,
    input  logic [DATA_WIDTH-1:0]                mem_rdata
);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCESS, RD_WAIT, DONE} state_t;

    state_t                  state;
    logic [X_ADDR_WIDTH-1:0] clr_x;
    logic [Y_ADDR_WIDTH-1:0] clr_y;
    logic [X_ADDR_WIDTH-1:0] nxt_x;
    logic [Y_ADDR_WIDTH-1:0] nxt_y;
    logic                    clr_last;
    logic                    owner;     // 0 = A, 1 = B
    logic                    acc_w_nr;
    logic [1:0]              rd_cnt;
    logic                    pick_b;
    logic                    can_grant;

    // Sweep walks x fastest; the carry into y happens on the last valid column.
    always_comb begin
        nxt_x    = clr_x + 1'b1;
        nxt_y    = clr_y;
        clr_last = 1'b0;
        if (clr_x == X_ADDR_WIDTH'(X_SIZE - 1)) begin
            nxt_x    = '0;
            nxt_y    = clr_y + 1'b1;
            clr_last = (clr_y == Y_ADDR_WIDTH'(Y_SIZE - 1));
        end
    end

`ifdef BOARD_ARB_FIXED_PRIO_EN
    always_comb pick_b = b_req & ~a_req;
`else
    logic rr_ptr;   // 0 = A has priority on a tie, 1 = B
    always_comb pick_b = b_req & (~a_req | rr_ptr);
`endif

    // The cycle that carries a done pulse still sees the finished requester's req high.
    always_comb can_grant = (a_req | b_req) & ~(a_done | b_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clr_x     <= '0;
            clr_y     <= '0;
            owner     <= 1'b0;
            acc_w_nr  <= 1'b0;
            rd_cnt    <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            a_gnt     <= 1'b0;
            a_rdata   <= '0;
            a_done    <= 1'b0;
            b_gnt     <= 1'b0;
            b_rdata   <= '0;
            b_done    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_w_nr  <= 1'b0;
`ifndef BOARD_ARB_FIXED_PRIO_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            clr_done <= 1'b0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state     <= CLEAR;
                        clr_busy  <= 1'b1;
                        clr_x     <= '0;
                        clr_y     <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= CLR_VALUE;
                        mem_w_nr  <= 1'b1;
                    end else if (can_grant) begin
                        state    <= ACCESS;
                        owner    <= pick_b;
                        a_gnt    <= ~pick_b;
                        b_gnt    <= pick_b;
                        if (pick_b) begin
                            mem_addr  <= b_addr;
                            mem_wdata <= b_wdata;
                            mem_w_nr  <= b_w_nr;
                            acc_w_nr  <= b_w_nr;
                        end else begin
                            mem_addr  <= a_addr;
                            mem_wdata <= a_wdata;
                            mem_w_nr  <= a_w_nr;
                            acc_w_nr  <= a_w_nr;
                        end
                    end
                end
                CLEAR: begin
                    if (clr_last) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                        mem_w_nr <= 1'b0;
                    end else begin
                        clr_x    <= nxt_x;
                        clr_y    <= nxt_y;
                        mem_addr <= {nxt_y, nxt_x};
                    end
                end
                ACCESS: begin
                    mem_w_nr <= 1'b0;
                    rd_cnt   <= '0;
                    state    <= acc_w_nr ? DONE : RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_cnt == 2'(RD_LATENCY - 1)) begin
                        if (owner) b_rdata <= mem_rdata;
                        else       a_rdata <= mem_rdata;
                        state <= DONE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    a_done <= ~owner;
                    b_done <= owner;
                    a_gnt  <= 1'b0;
                    b_gnt  <= 1'b0;
                    state  <= IDLE;
`ifndef BOARD_ARB_FIXED_PRIO_EN
                    rr_ptr <= ~owner;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
